logic_op_arbiter: RTL and testbench

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

---
 rtl/logic_op_arbiter.sv | 153 +++++++++++++++
 tb/tb_logic_op_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_arbiter.sv
// Two-requester round-robin arbiter in front of a shared registered bitwise logic unit.
// Optional build macro LOGIC_ARB_ERR_EN adds the err port and makes opcode 7 an error.
module logic_op_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] y,
    output logic             busy
`ifdef LOGIC_ARB_ERR_EN
    ,
    output logic             err
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             served_q, served_d;
    logic             ptr_q, ptr_d;
    logic             win1;
`ifdef LOGIC_ARB_ERR_EN
    logic             err_q, err_d;
`endif

    function automatic logic [WIDTH-1:0] logic_unit(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = ~a;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = a ^ b;
            3'd6:    r = ~(a ^ b);
`ifdef LOGIC_ARB_ERR_EN
            default: r = '0;
`else
            default: r = a;
`endif
        endcase
        return r;
    endfunction

    // Requester 1 wins alone, or under contention when requester 0 was served last.
    assign win1 = req1 & (~req0 | ~ptr_q);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        y_d      = y_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        served_d = served_q;
        ptr_d    = ptr_q;
`ifdef LOGIC_ARB_ERR_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    state_d  = ST_EXEC;
                    served_d = win1;
                    op_d     = win1 ? op1 : op0;
                    a_d      = win1 ? a1 : a0;
                    b_d      = win1 ? b1 : b0;
                    gnt_d    = win1 ? 2'b10 : 2'b01;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                y_d     = logic_unit(op_q, a_q, b_q);
                done_d  = served_q ? 2'b10 : 2'b01;
`ifdef LOGIC_ARB_ERR_EN
                err_d   = (op_q == 3'd7);
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = served_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            served_q <= 1'b0;
            ptr_q    <= 1'b1;
`ifdef LOGIC_ARB_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            y_q      <= y_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            served_q <= served_d;
            ptr_q    <= ptr_d;
`ifdef LOGIC_ARB_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    assign gnt0  = gnt_q[0];
    assign gnt1  = gnt_q[1];
    assign done0 = done_q[0];
    assign done1 = done_q[1];
    assign y     = y_q;
    assign busy  = (state_q != ST_IDLE);
`ifdef LOGIC_ARB_ERR_EN
    assign err   = err_q;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter (WIDTH=8) against a behavioural model.
module tb_logic_op_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [2:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [7:0] y;
`ifdef LOGIC_ARB_ERR_EN
    logic       err;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int last      = 1;

    logic_op_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .y(y), .busy(busy)
`ifdef LOGIC_ARB_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_f(input int op, input logic [7:0] a, input logic [7:0] b);
        if (op == 0) return a & b;
        if (op == 1) return a | b;
        if (op == 2) return ~a;
        if (op == 3) return ~(a & b);
        if (op == 4) return ~(a | b);
        if (op == 5) return a ^ b;
        if (op == 6) return ~(a ^ b);
`ifdef LOGIC_ARB_ERR_EN
        return 8'h00;
`else
        return a;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        step();
        step();
        total_cnt++; if ({gnt1, gnt0} !== 2'b00) $display("FAIL reset_gnt got %b want 00", {gnt1, gnt0}); else pass_cnt++;
        total_cnt++; if ({done1, done0} !== 2'b00) $display("FAIL reset_done got %b want 00", {done1, done0}); else pass_cnt++;
        total_cnt++; if (y !== 8'h00) $display("FAIL reset_y got %h want 00", y); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
`ifdef LOGIC_ARB_ERR_EN
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
`endif
        rst_n = 1'b1;
        last = 1;
        $display("txn reset released");
    endtask

    task automatic test_xor_basic();
        req0 = 1; op0 = 3'd5; a0 = 8'hF0; b0 = 8'h3C;
        step();
        total_cnt++; if ({gnt1, gnt0} !== 2'b01) $display("FAIL xor_gnt got %b want 01", {gnt1, gnt0}); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL xor_busy1 got %b want 1", busy); else pass_cnt++;
        total_cnt++; if ({done1, done0} !== 2'b00) $display("FAIL xor_early_done got %b want 00", {done1, done0}); else pass_cnt++;
        req0 = 0;
        step();
        total_cnt++; if ({done1, done0} !== 2'b01) $display("FAIL xor_done got %b want 01", {done1, done0}); else pass_cnt++;
        total_cnt++; if (y !== 8'hCC) $display("FAIL xor_y got %h want cc", y); else pass_cnt++;
        total_cnt++; if ({gnt1, gnt0} !== 2'b00) $display("FAIL xor_gnt_width got %b want 00", {gnt1, gnt0}); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL xor_busy2 got %b want 1", busy); else pass_cnt++;
        step();
        total_cnt++; if (busy !== 1'b0) $display("FAIL xor_idle_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if ({done1, done0} !== 2'b00) $display("FAIL xor_done_width got %b want 00", {done1, done0}); else pass_cnt++;
        total_cnt++; if (y !== 8'hCC) $display("FAIL xor_y_hold got %h want cc", y); else pass_cnt++;
        last = 0;
        $display("txn xor req0 y=%h", y);
    endtask

    task automatic test_round_robin();
        int w;
        int prev;
        logic [7:0] exp_y;
        rst_n = 1'b0;
        req0 = 1; req1 = 1; op0 = 3'd0; op1 = 3'd1;
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        last = 1;
        prev = 0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = (last == 0) ? 1 : 0;
            total_cnt++; if (w != (i % 2)) $display("FAIL rr_model_order got %0d want %0d", w, i % 2); else pass_cnt++;
            step();
            total_cnt++; if ({gnt1, gnt0} !== ((w == 1) ? 2'b10 : 2'b01)) $display("FAIL rr_gnt%0d got %b want winner %0d", i, {gnt1, gnt0}, w); else pass_cnt++;
            if (i > 0) begin
                total_cnt++; if (cyc - prev != 3) $display("FAIL rr_spacing got %0d want 3", cyc - prev); else pass_cnt++;
            end
            prev = cyc;
            step();
            exp_y = (w == 1) ? ref_f(1, a1, b1) : ref_f(0, a0, b0);
            total_cnt++; if ({done1, done0} !== ((w == 1) ? 2'b10 : 2'b01)) $display("FAIL rr_done%0d got %b want winner %0d", i, {done1, done0}, w); else pass_cnt++;
            total_cnt++; if (y !== exp_y) $display("FAIL rr_y%0d got %h want %h", i, y, exp_y); else pass_cnt++;
            step();
            total_cnt++; if (busy !== 1'b0) $display("FAIL rr_idle%0d got busy %b want 0", i, busy); else pass_cnt++;
            last = w;
            $display("txn rr winner=%0d y=%h", w, exp_y);
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_opcode_sweep();
        logic [7:0] exp_tab [7];
        exp_tab = '{8'h0A, 8'hAF, 8'h55, 8'hF5, 8'h50, 8'hA5, 8'h5A};
        for (int op = 0; op < 7; op++) begin
            step();
            req0 = 1; op0 = 3'(op); a0 = 8'hAA; b0 = 8'h0F;
            step();
            total_cnt++; if (gnt0 !== 1'b1) $display("FAIL sweep_gnt op%0d got %b want 1", op, gnt0); else pass_cnt++;
            req0 = 0;
            step();
            total_cnt++; if (y !== exp_tab[op] || done0 !== 1'b1) $display("FAIL sweep_y op%0d got %h/done %b want %h/1", op, y, done0, exp_tab[op]); else pass_cnt++;
            last = 0;
            $display("txn sweep op=%0d y=%h", op, y);
        end
        step();
    endtask

    task automatic test_operand_hold();
        req0 = 1; op0 = 3'd1; a0 = 8'h81; b0 = 8'h02;
        step();
        total_cnt++; if (gnt0 !== 1'b1) $display("FAIL hold_gnt got %b want 1", gnt0); else pass_cnt++;
        req0 = 0; a0 = 8'h00; b0 = 8'hFF; op0 = 3'd0;
        step();
        total_cnt++; if (y !== 8'h83) $display("FAIL hold_y got %h want 83", y); else pass_cnt++;
        step();
        last = 0;
        $display("txn hold y=%h", y);
    endtask

    task automatic test_reset_midop();
        logic [7:0] exp_y;
        req1 = 1; op1 = 3'd5; a1 = 8'h33; b1 = 8'h0F;
        step();
        total_cnt++; if (gnt1 !== 1'b1) $display("FAIL abort_gnt got %b want 1", gnt1); else pass_cnt++;
        req1 = 0;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (y !== 8'h00) $display("FAIL abort_y got %h want 00", y); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (gnt1 !== 1'b0) $display("FAIL abort_gnt_clr got %b want 0", gnt1); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++; if ({done1, done0} !== 2'b00) $display("FAIL abort_done got %b want 00", {done1, done0}); else pass_cnt++;
        end
        rst_n = 1'b1;
        last = 1;
        req1 = 1; op1 = 3'd6; a1 = 8'($urandom); b1 = 8'($urandom);
        exp_y = ref_f(6, a1, b1);
        step();
        total_cnt++; if ({gnt1, gnt0} !== 2'b10) $display("FAIL abort_next_gnt got %b want 10", {gnt1, gnt0}); else pass_cnt++;
        req1 = 0;
        step();
        total_cnt++; if (done1 !== 1'b1 || y !== exp_y) $display("FAIL abort_next_y got %h/done %b want %h/1", y, done1, exp_y); else pass_cnt++;
        step();
        last = 1;
        $display("txn abort then req1 y=%h", y);
    endtask

    task automatic test_opcode7();
        req0 = 1; op0 = 3'd7; a0 = 8'h5A; b0 = 8'($urandom);
        step();
        total_cnt++; if (gnt0 !== 1'b1) $display("FAIL op7_gnt got %b want 1", gnt0); else pass_cnt++;
`ifdef LOGIC_ARB_ERR_EN
        total_cnt++; if (err !== 1'b0) $display("FAIL op7_err_early got %b want 0", err); else pass_cnt++;
`endif
        req0 = 0;
        step();
        total_cnt++; if (done0 !== 1'b1) $display("FAIL op7_done got %b want 1", done0); else pass_cnt++;
`ifdef LOGIC_ARB_ERR_EN
        total_cnt++; if (y !== 8'h00) $display("FAIL op7_y got %h want 00", y); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL op7_err got %b want 1", err); else pass_cnt++;
`else
        total_cnt++; if (y !== 8'h5A) $display("FAIL op7_y got %h want 5a", y); else pass_cnt++;
`endif
        step();
`ifdef LOGIC_ARB_ERR_EN
        total_cnt++; if (err !== 1'b0) $display("FAIL op7_err_width got %b want 0", err); else pass_cnt++;
`endif
        last = 0;
        $display("txn op7 y=%h", y);
    endtask

    task automatic test_random();
        int pat, w, gap;
        logic [2:0] lop;
        logic [7:0] la, lb, exp_y;
        for (int i = 0; i < 20; i++) begin
            pat = $urandom_range(1, 3);
            req0 = pat[0]; req1 = pat[1];
            op0 = 3'($urandom); op1 = 3'($urandom);
            a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            w = (pat == 3) ? ((last == 0) ? 1 : 0) : ((pat == 2) ? 1 : 0);
            lop = (w == 1) ? op1 : op0;
            la = (w == 1) ? a1 : a0;
            lb = (w == 1) ? b1 : b0;
            exp_y = ref_f(int'(lop), la, lb);
            step();
            total_cnt++; if ({gnt1, gnt0} !== ((w == 1) ? 2'b10 : 2'b01)) $display("FAIL rand_gnt%0d got %b want winner %0d", i, {gnt1, gnt0}, w); else pass_cnt++;
            req0 = 1'($urandom); req1 = 1'($urandom);
            op0 = 3'($urandom); op1 = 3'($urandom);
            a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            step();
            total_cnt++; if ({done1, done0} !== ((w == 1) ? 2'b10 : 2'b01) || y !== exp_y) $display("FAIL rand_done%0d got %b y=%h want winner %0d y=%h", i, {done1, done0}, y, w, exp_y); else pass_cnt++;
            req0 = 0; req1 = 0;
            step();
            total_cnt++; if (busy !== 1'b0 || y !== exp_y) $display("FAIL rand_idle%0d got busy %b y=%h want 0 y=%h", i, busy, y, exp_y); else pass_cnt++;
            last = w;
            $display("txn rand %0d req=%b winner=%0d op=%0d a=%h b=%h y=%h", i, pat[1:0], w, lop, la, lb, exp_y);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step();
                total_cnt++; if (busy !== 1'b0) $display("FAIL rand_gap_busy got %b want 0", busy); else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_xor_basic();
        test_round_robin();
        test_opcode_sweep();
        test_operand_hold();
        test_reset_midop();
        test_opcode7();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
